// File: rtl/simple_acc_pkg.sv
// Shared types and constants for the simple accelerator datapath blocks.
package simple_acc_pkg;

    localparam int SpatParDef   = 4;
    localparam int DataWidthDef = 64;
    localparam int DepthDef     = 4;
    localparam int BeatCntWidth = 32;

    typedef logic [DataWidthDef-1:0] lane_elem_t;

    // Extracts lane idx from a packed multi-lane bus (lane i at [i*DataWidth +: DataWidth]).
    function automatic lane_elem_t lane_slice(
        input logic [SpatParDef*DataWidthDef-1:0] bus,
        input int                                 idx
    );
        return bus[idx*DataWidthDef +: DataWidthDef];
    endfunction

endpackage

// File: rtl/simple_lane_fifo.sv
// Single-clock per-lane FIFO; head is read straight from the storage register at rd_ptr,
// so a newly pushed element becomes visible one cycle after the push (no fall-through).
module simple_lane_fifo #(
    parameter int DataWidth = 64,
    parameter int Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [CntWidth-1:0]  count;
    logic                 push_ok;
    logic                 pop_ok;

    // A full lane refuses a push even when it pops in the same cycle.
    always_comb begin
        full_o  = (count == CntWidth'(Depth));
        empty_o = (count == '0);
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        head_o  = mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i && !clear_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo Depth.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simple_lane_gather.sv
// Re-joins SpatPar independent lane result streams into one wide stream; a wide word
// leaves only when every lane FIFO holds data, and all lanes pop together.
module simple_lane_gather
    import simple_acc_pkg::*;
#(
    parameter int SpatPar   = SpatParDef,
    parameter int DataWidth = DataWidthDef,
    parameter int Depth     = DepthDef
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic [SpatPar*DataWidth-1:0] lane_data_i,
    input  logic [SpatPar-1:0]           lane_valid_i,
    output logic [SpatPar-1:0]           lane_ready_o,
    output logic [SpatPar*DataWidth-1:0] data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [BeatCntWidth-1:0]      beat_cnt_o
);

    logic [SpatPar-1:0]   lane_full;
    logic [SpatPar-1:0]   lane_empty;
    logic [DataWidth-1:0] lane_head [SpatPar];
    logic                 word_pop;

    // A clear cycle discards any pop so the flush wins over the handshake.
    assign valid_o      = &(~lane_empty);
    assign word_pop     = valid_o && ready_i && !clear_i;
    assign lane_ready_o = ~lane_full;

    for (genvar gi = 0; gi < SpatPar; gi++) begin : g_lane
        simple_lane_fifo #(
            .DataWidth (DataWidth),
            .Depth     (Depth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (lane_valid_i[gi]),
            .data_i  (lane_data_i[gi*DataWidth +: DataWidth]),
            .pop_i   (word_pop),
            .head_o  (lane_head[gi]),
            .full_o  (lane_full[gi]),
            .empty_o (lane_empty[gi])
        );
    end

    // Joined word is the lane heads side by side, forced to zero while not valid.
    always_comb begin
        data_o = '0;
        if (valid_o) begin
            for (int i = 0; i < SpatPar; i++) begin
                data_o[i*DataWidth +: DataWidth] = lane_head[i];
            end
        end
    end

    // Counts joined words taken downstream; wraps naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            beat_cnt_o <= '0;
        end else if (word_pop) begin
            beat_cnt_o <= beat_cnt_o + BeatCntWidth'(1);
        end
    end

endmodule

// File: tb/tb_simple_lane_gather.sv
// Self-checking bench for simple_lane_gather: directed phases plus a random phase,
// with a per-lane model feeding an expected-word queue checked by a negedge monitor.
module tb_simple_lane_gather;
    import simple_acc_pkg::*;

    localparam int Lanes = 4;
    localparam int DW    = 64;
    localparam int Depth = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                clear_i;
    logic [Lanes*DW-1:0] lane_data_i;
    logic [Lanes-1:0]    lane_valid_i;
    logic [Lanes-1:0]    lane_ready_o;
    logic [Lanes*DW-1:0] data_o;
    logic                valid_o;
    logic                ready_i;
    logic [31:0]         beat_cnt_o;

    int checks   = 0;
    int failures = 0;

    lane_elem_t          lane_in [Lanes][$];
    logic [Lanes*DW-1:0] exp_q [$];
    logic [31:0]         exp_beats = '0;
    logic [Lanes-1:0]    last_acc  = '0;
    logic                prev_hold = 1'b0;
    logic [Lanes*DW-1:0] prev_data = '0;
    logic [Lanes-1:0]    exp_ready;
    logic                exp_valid;
    logic [Lanes*DW-1:0] word;
    logic                all_have;

    simple_lane_gather #(
        .SpatPar   (Lanes),
        .DataWidth (DW),
        .Depth     (Depth)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .lane_data_i  (lane_data_i),
        .lane_valid_i (lane_valid_i),
        .lane_ready_o (lane_ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .beat_cnt_o   (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3, input logic rdy);
        lane_valid_i = v;
        lane_data_i  = {d3, d2, d1, d0};
        ready_i      = rdy;
    endtask

    // Monitor and model: checks outputs against the model, then records this cycle's handshakes.
    always @(negedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Lanes; i++) lane_in[i].delete();
            exp_q.delete();
            exp_beats = '0;
            last_acc  = '0;
            prev_hold = 1'b0;
        end else begin
            exp_valid = (exp_q.size() > 0);
            for (int i = 0; i < Lanes; i++) begin
                exp_ready[i] = ((lane_in[i].size() + exp_q.size()) < Depth);
            end
            checkOutput("lane_ready", 256'(lane_ready_o), 256'(exp_ready));
            checkOutput("valid", 256'(valid_o), 256'(exp_valid));
            checkOutput("beat_cnt", 256'(beat_cnt_o), 256'(exp_beats));
            if (prev_hold) begin
                checkOutput("valid_hold", 256'(valid_o), 256'(1));
                checkOutput("data_hold", 256'(data_o), 256'(prev_data));
            end
            if (!valid_o) begin
                checkOutput("data_idle", 256'(data_o), 256'(0));
            end else if (exp_q.size() > 0) begin
                checkOutput("data_word", 256'(data_o), 256'(exp_q[0]));
            end
            if (clear_i) begin
                for (int i = 0; i < Lanes; i++) lane_in[i].delete();
                exp_q.delete();
                exp_beats = '0;
                last_acc  = '0;
                prev_hold = 1'b0;
            end else begin
                prev_hold = valid_o && !ready_i;
                prev_data = data_o;
                if (exp_valid && ready_i) begin
                    void'(exp_q.pop_front());
                    exp_beats = exp_beats + 32'd1;
                end
                for (int i = 0; i < Lanes; i++) begin
                    last_acc[i] = lane_valid_i[i] && exp_ready[i];
                    if (last_acc[i]) lane_in[i].push_back(lane_slice(lane_data_i, i));
                end
                all_have = 1'b1;
                for (int i = 0; i < Lanes; i++) if (lane_in[i].size() == 0) all_have = 1'b0;
                while (all_have) begin
                    for (int i = 0; i < Lanes; i++) begin
                        word[i*DW +: DW] = lane_in[i].pop_front();
                        if (lane_in[i].size() == 0) all_have = 1'b0;
                    end
                    exp_q.push_back(word);
                end
            end
        end
    end

    // Stimulus: directed phases followed by a random phase honouring the hold-until-accepted rule.
    initial begin
        rst_i   = 1'b1;
        clear_i = 1'b0;
        applyStimulus(4'hF, 64'h1, 64'h2, 64'h3, 64'h4, 1'b1);
        tick();
        tick();
        rst_i = 1'b0;
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("reset_ready", 256'(lane_ready_o), 256'(4'b1111));
        checkOutput("reset_valid", 256'(valid_o), 256'(0));
        checkOutput("reset_data", 256'(data_o), 256'(0));
        checkOutput("reset_beat", 256'(beat_cnt_o), 256'(0));
        tick();

        applyStimulus(4'b0001, 64'h10, 0, 0, 0, 1'b1);
        tick();
        applyStimulus(4'b0010, 0, 64'h20, 0, 0, 1'b1);
        tick();
        applyStimulus(4'b0100, 0, 0, 64'h30, 0, 1'b1);
        tick();
        applyStimulus(4'b1000, 0, 0, 0, 64'h40, 1'b1);
        @(negedge clk_i);
        checkOutput("skew_valid_early", 256'(valid_o), 256'(0));
        tick();
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("skew_valid", 256'(valid_o), 256'(1));
        checkOutput("skew_data", 256'(data_o), {64'h40, 64'h30, 64'h20, 64'h10});
        tick();
        @(negedge clk_i);
        checkOutput("skew_beat", 256'(beat_cnt_o), 256'(1));
        checkOutput("skew_drained", 256'(valid_o), 256'(0));
        tick();

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            applyStimulus(4'b0001, 64'h100 + 64'(j), 0, 0, 0, 1'b0);
            if (j == 4) begin
                @(negedge clk_i);
                checkOutput("bp_lane0_full", 256'(lane_ready_o[0]), 256'(0));
            end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            applyStimulus(4'b1111, 64'h104, 64'h200 + 64'(j), 64'h300 + 64'(j), 64'h400 + 64'(j), 1'b0);
            tick();
        end
        applyStimulus(4'b0001, 64'h104, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("bp_first_valid", 256'(valid_o), 256'(1));
        checkOutput("bp_first_data", 256'(data_o), {64'h400, 64'h300, 64'h200, 64'h100});
        tick();
        @(negedge clk_i);
        checkOutput("bp_word2_valid", 256'(valid_o), 256'(1));
        tick();
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("bp_word3_valid", 256'(valid_o), 256'(1));
        tick();
        @(negedge clk_i);
        checkOutput("bp_word4_valid", 256'(valid_o), 256'(1));
        tick();
        @(negedge clk_i);
        checkOutput("bp_beats", 256'(beat_cnt_o), 256'(4));
        checkOutput("bp_lane0_ready", 256'(lane_ready_o[0]), 256'(1));
        checkOutput("bp_done_valid", 256'(valid_o), 256'(0));
        tick();

        applyStimulus(4'b0011, 64'h500, 64'h600, 0, 0, 1'b0);
        tick();
        applyStimulus(4'b0010, 0, 64'h601, 0, 0, 1'b0);
        tick();
        applyStimulus(4'b1111, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 1'b1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("clr_ready", 256'(lane_ready_o), 256'(4'b1111));
        checkOutput("clr_valid", 256'(valid_o), 256'(0));
        checkOutput("clr_data", 256'(data_o), 256'(0));
        checkOutput("clr_beat", 256'(beat_cnt_o), 256'(0));
        tick();
        applyStimulus(4'b1111, 64'h70, 64'h71, 64'h72, 64'h73, 1'b1);
        tick();
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("clr_after_data", 256'(data_o), {64'h73, 64'h72, 64'h71, 64'h70});
        tick();

        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int s = 0; s < 100; s++) begin
            applyStimulus(4'b1111, 64'(s * 16), 64'(s * 16 + 1), 64'(s * 16 + 2), 64'(s * 16 + 3), 1'b1);
            if (s >= 1) begin
                @(negedge clk_i);
                checkOutput("stream_no_gap", 256'(valid_o), 256'(1));
            end
            tick();
        end
        applyStimulus(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk_i);
        checkOutput("stream_beats", 256'(beat_cnt_o), 256'(99));
        tick();
        tick();

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < Lanes; i++) begin
                if (!(lane_valid_i[i] && !last_acc[i])) begin
                    lane_valid_i[i] = ($urandom_range(0, 2) != 0);
                    lane_data_i[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < Lanes; i++) begin
                if (last_acc[i]) lane_valid_i[i] = 1'b0;
            end
            ready_i = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
